// File: rtl/q_measure.sv
// Q measurement stage: settles after enable or a reference change, then reduces each
// window of 2^AVG_LOG2 samples to one q_measured value with a one-cycle ready pulse.
// Optional feature macro: Q_MEASURE_PEAK_EN (window maximum instead of truncated mean).
module q_measure #(
  parameter int unsigned WIDTH         = 10,
  parameter int unsigned AVG_LOG2      = 3,
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             iref_changed,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] q_measured,
  output logic             ready,
  output logic             settling
);

  localparam int unsigned N           = 1 << AVG_LOG2;
  localparam int unsigned CNT_W       = AVG_LOG2 + 1;
  localparam int unsigned SET_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
`ifdef Q_MEASURE_PEAK_EN
  localparam int unsigned ACC_W       = WIDTH;
`else
  localparam int unsigned ACC_W       = WIDTH + AVG_LOG2;
`endif

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_e;

  // With no settling interval a (re)start goes straight to accumulation.
  localparam state_e START = (SETTLE_CYCLES == 0) ? ACCUM : SETTLE;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_measured_q, q_measured_d;
  logic               ready_q, ready_d;
  logic               settling_q, settling_d;

  logic [ACC_W-1:0]   acc_next;
  logic [WIDTH-1:0]   result;

  // Window reduction including the sample currently presented.
  always_comb begin
`ifdef Q_MEASURE_PEAK_EN
    acc_next = (sample > acc_q) ? sample : acc_q;
    result   = acc_next;
`else
    acc_next = acc_q + ACC_W'(sample);
    result   = acc_next[ACC_W-1:AVG_LOG2];
`endif
  end

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    q_measured_d = q_measured_q;

    unique case (state_q)
      IDLE: begin
        settle_d = '0;
        cnt_d    = '0;
        acc_d    = '0;
        if (enable) state_d = START;
      end
      SETTLE: begin
        if (iref_changed) begin
          settle_d = '0;
        end else if (settle_q == SET_W'(SETTLE_LAST)) begin
          settle_d = '0;
          state_d  = ACCUM;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ACCUM: begin
        if (iref_changed) begin
          state_d  = START;
          settle_d = '0;
          cnt_d    = '0;
          acc_d    = '0;
        end else if (sample_valid) begin
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d      = DONE;
            q_measured_d = result;
            cnt_d        = '0;
            acc_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = acc_next;
          end
        end
      end
      DONE: begin
        settle_d = '0;
        cnt_d    = '0;
        acc_d    = '0;
        state_d  = iref_changed ? START : ACCUM;
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a window completing this cycle.
    if (!enable) begin
      state_d      = IDLE;
      settle_d     = '0;
      cnt_d        = '0;
      acc_d        = '0;
      q_measured_d = q_measured_q;
    end

    ready_d    = (state_d == DONE);
    settling_d = (state_d == SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      q_measured_q <= '0;
      ready_q      <= 1'b0;
      settling_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      q_measured_q <= q_measured_d;
      ready_q      <= ready_d;
      settling_q   <= settling_d;
    end
  end

  assign q_measured = q_measured_q;
  assign ready      = ready_q;
  assign settling   = settling_q;

endmodule

// File: tb/tb_q_measure.sv
// Directed bench for q_measure (SETTLE_CYCLES=4, N=8): per-cycle vector table plus
// hand sequences for first-result latency and a reference change on the Nth sample.
module tb_q_measure;

  logic       clk = 1'b0;
  logic       rst, enable, iref_changed, sample_valid;
  logic [9:0] sample;
  logic [9:0] q_measured;
  logic       ready, settling;

  int checks = 0;
  int errors = 0;

`ifdef Q_MEASURE_PEAK_EN
  localparam logic [9:0] EXP_A = 10'd17;
  localparam logic [9:0] EXP_C = 10'd7;
  localparam logic [9:0] EXP_D = 10'd47;
  localparam logic [9:0] EXP_F = 10'd9;
`else
  localparam logic [9:0] EXP_A = 10'd13;
  localparam logic [9:0] EXP_C = 10'd0;
  localparam logic [9:0] EXP_D = 10'd43;
  localparam logic [9:0] EXP_F = 10'd4;
`endif

  typedef struct {
    logic       rst, en, iref, sv;
    logic [9:0] smp;
    logic [9:0] q;
    logic       rdy, stl;
  } vec_t;

  vec_t vecs[$];

  q_measure #(.WIDTH(10), .AVG_LOG2(3), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .iref_changed(iref_changed),
    .sample_valid(sample_valid), .sample(sample), .q_measured(q_measured),
    .ready(ready), .settling(settling)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic en, input logic ir, input logic sv,
                     input logic [9:0] smp, input logic [9:0] q, input logic rdy,
                     input logic stl);
    vecs.push_back('{r, en, ir, sv, smp, q, rdy, stl});
  endtask

  task automatic add_n(input int n, input logic en, input logic ir, input logic sv,
                       input logic [9:0] smp, input logic [9:0] q, input logic stl);
    for (int i = 0; i < n; i++) add(1'b0, en, ir, sv, smp, q, 1'b0, stl);
  endtask

  initial begin
    logic [9:0] peak_vals [8];
    int         cyc;
    bit         seen;

    peak_vals = '{10'd3, 10'd9, 10'd2, 10'd9, 10'd1, 10'd0, 10'd5, 10'd4};
    rst = 1'b1; enable = 1'b0; iref_changed = 1'b0; sample_valid = 1'b0; sample = '0;

    // Reset, enable, 4 settle cycles dropping samples, then window 10..17
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add_n(4, 1, 0, 1, 10'd1000, 0, 1);
    add_n(1, 1, 0, 1, 10'd1000, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, 10'(10 + i), 0, 0, 0);
    add(0, 1, 0, 1, 10'd17, EXP_A, 1, 0);
    // Sample during DONE is dropped; then all-1023 window and truncation window
    add(0, 1, 0, 1, 10'd500, EXP_A, 0, 0);
    add_n(7, 1, 0, 1, 10'd1023, EXP_A, 0);
    add(0, 1, 0, 1, 10'd1023, 10'd1023, 1, 0);
    add_n(1, 1, 0, 0, 0, 10'd1023, 0);
    add_n(7, 1, 0, 1, 0, 10'd1023, 0);
    add(0, 1, 0, 1, 10'd7, EXP_C, 1, 0);
    // Reference change on the 5th sample: 4 settle cycles, fresh window 40..47
    add_n(1, 1, 0, 0, 0, EXP_C, 0);
    add_n(4, 1, 0, 1, 10'd100, EXP_C, 0);
    add(0, 1, 1, 1, 10'd100, EXP_C, 0, 1);
    add_n(3, 1, 0, 1, 10'd900, EXP_C, 1);
    add_n(1, 1, 0, 1, 10'd900, EXP_C, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, 10'(40 + i), EXP_C, 0, 0);
    add(0, 1, 0, 1, 10'd47, EXP_D, 1, 0);
    // Disable mid-window, re-enable: q held, settling restarts, window of 8s
    add_n(1, 1, 0, 0, 0, EXP_D, 0);
    add_n(3, 1, 0, 1, 10'd200, EXP_D, 0);
    add_n(2, 0, 0, 1, 10'd200, EXP_D, 0);
    add_n(4, 1, 0, 0, 0, EXP_D, 1);
    add_n(1, 1, 0, 0, 0, EXP_D, 0);
    add_n(7, 1, 0, 1, 10'd8, EXP_D, 0);
    add(0, 1, 0, 1, 10'd8, 10'd8, 1, 0);
    // Reset mid-window with enable high, then recovery and window of 1s
    add_n(1, 1, 0, 0, 0, 10'd8, 0);
    add_n(3, 1, 0, 1, 10'd50, 10'd8, 0);
    add(1, 1, 0, 1, 10'd50, 0, 0, 0);
    add(1, 1, 0, 1, 10'd50, 0, 0, 0);
    add_n(4, 1, 0, 0, 0, 0, 1);
    add_n(1, 1, 0, 0, 0, 0, 0);
    add_n(7, 1, 0, 1, 10'd1, 0, 0);
    add(0, 1, 0, 1, 10'd1, 10'd1, 1, 0);
    // Reference change during DONE restarts settling; then peak-vs-mean window
    add(0, 1, 1, 0, 0, 10'd1, 0, 1);
    add_n(3, 1, 0, 0, 0, 10'd1, 1);
    add_n(1, 1, 0, 0, 0, 10'd1, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 0, 1, peak_vals[i], 10'd1, 0, 0);
    add(0, 1, 0, 1, peak_vals[7], EXP_F, 1, 0);
    add_n(1, 1, 0, 0, 0, EXP_F, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; enable = vecs[i].en; iref_changed = vecs[i].iref;
      sample_valid = vecs[i].sv; sample = vecs[i].smp;
      @(posedge clk); #1;
      check($sformatf("v%0d q_measured", i), int'(q_measured), int'(vecs[i].q));
      check($sformatf("v%0d ready", i), int'(ready), int'(vecs[i].rdy));
      check($sformatf("v%0d settling", i), int'(settling), int'(vecs[i].stl));
    end

    // First-result latency: ready after edge e+1+4+8-1, i.e. 12 edges after edge e
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; iref_changed = 1'b0; sample_valid = 1'b0;
    @(posedge clk); #1;
    check("reset ready", int'(ready), 0);
    check("reset q", int'(q_measured), 0);
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b1; sample = 10'd5;
    cyc = -1; seen = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (!seen) begin
        @(posedge clk); #1;
        if (ready) begin cyc = c; seen = 1'b1; end
      end
    end
    check("first ready latency", cyc, 12);
    check("latency q", int'(q_measured), 5);

    // Reference change together with the Nth sample: no result produced
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("pre-nth ready c%0d", c), int'(ready), 0);
    end
    @(negedge clk);
    iref_changed = 1'b1;
    @(posedge clk); #1;
    check("nth iref ready", int'(ready), 0);
    check("nth iref settling", int'(settling), 1);
    @(negedge clk);
    iref_changed = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("post-nth ready c%0d", c), int'(ready), 0);
    end
    check("post-nth q held", int'(q_measured), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_measure.md
# q_measure

Upstream measurement stage of the instability search loop. Collects ADC samples of the measured Q after each reference-current step and waits out a settling interval first. Reduces each window of samples to one `q_measured` value. Issues the single-cycle `ready` pulse consumed by the instability detector, which uses that value to decide whether to lower `i_ref_setup` again.

## Interface
- `WIDTH`, 10: sample and result width, matching the detector's `q_measured` width.
- `AVG_LOG2`, 3: log2 of samples per window (N = 2^AVG_LOG2 = 8).
- `SETTLE_CYCLES`, 64: clock cycles ignored after enable or a reference change; 0 disables settling.

- `clk` input 1: system clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: measurement enable; the same signal that drives the detector's `enable`.
- `iref_changed` input 1: one-cycle strobe issued when `i_ref_setup` or the applied reference changes.
- `sample_valid` input 1: ADC sample strobe.
- `sample` input WIDTH: unsigned ADC sample.
- `q_measured` output WIDTH: window result, held between `ready` pulses.
- `ready` output 1: one-cycle pulse marking a new `q_measured`.
- `settling` output 1: high while in SETTLE.

## Operation
- State machine states are IDLE, SETTLE, ACCUM and DONE.
- IDLE:
  - `enable`=1 moves to SETTLE, or directly to ACCUM when SETTLE_CYCLES=0.
  - The settle counter and accumulator are cleared.
- SETTLE:
  - The counter increments each cycle.
  - The state moves to ACCUM on the cycle the counter reaches SETTLE_CYCLES-1, so exactly SETTLE_CYCLES cycles are spent in SETTLE.
  - Samples are dropped.
- ACCUM:
  - Each `sample_valid` cycle adds `sample` to the accumulator and increments the sample counter (AVG_LOG2+1 bits).
  - When the Nth sample is accepted, the state moves to DONE.
- DONE:
  - Lasts exactly one cycle with `ready`=1; `q_measured` is already updated.
  - The sample counter and accumulator are cleared.
  - The state then returns to ACCUM, so measurement is continuous at a fixed reference.
  - A sample presented during DONE is dropped.
- Arithmetic:
  - The accumulator is WIDTH+AVG_LOG2 bits unsigned and cannot overflow.
  - Result = accumulator[WIDTH+AVG_LOG2-1:AVG_LOG2], i.e. truncating division by N.
  - The Nth sample is included in the result.
- `iref_changed`=1 in SETTLE, ACCUM or DONE:
  - Discards the partial window and restarts SETTLE with the counter at 0.
  - A DONE cycle still emits its `ready`, because its window completed before the change.
  - The following state is SETTLE, not ACCUM.
- Simultaneous `iref_changed` and `sample_valid` in ACCUM:
  - `iref_changed` wins and the sample is dropped.
  - If that sample would have been the Nth, no result is produced.
- `enable`=0 in any state:
  - Next state is IDLE, the window is discarded, `ready` is 0 and `q_measured` is held.
  - `enable`=0 has priority over `iref_changed`.
- `rst`=1:
  - Next cycle has state IDLE and all counters and the accumulator at 0.
  - Outputs become `q_measured`=0, `ready`=0, `settling`=0.
  - Reset mid-window discards the window without emitting `ready`.

## Timing
- A sample is accepted on the rising edge where state=ACCUM and `sample_valid`=1.
- If the Nth sample is accepted at edge k:
  - `q_measured` and `ready`=1 are visible after edge k, for one cycle.
  - `ready` deasserts after edge k+1.
- Minimum spacing between `ready` pulses is N+1 cycles, given back-to-back `sample_valid`.
- First result after `enable` rises at edge e:
  - Earliest `ready` is after edge e+1+SETTLE_CYCLES+N-1.
  - That edge is when the Nth consecutive sample is accepted.
- `settling`:
  - Asserted from the edge entering SETTLE.
  - Deasserted on the edge entering ACCUM.
- `q_measured` and `ready` are registered outputs with no combinational input-to-output path.

## Configuration
- Macro: `Q_MEASURE_PEAK_EN`.
- Defined:
  - The accumulator is replaced by a WIDTH-bit running maximum, cleared to 0 at window start.
  - `q_measured` = maximum sample of the window.
  - Timing and all other behaviour are unchanged.
- Undefined: truncated mean as described above.

## Test plan
- Reset, then `enable`=1 with SETTLE_CYCLES=4, AVG_LOG2=3, `sample_valid` every cycle with values 10..17 after settling:
  - `ready` pulses once with `q_measured`=13 ((108)>>3).
  - Earliest `ready` occurs at the latency given in Timing.
- Samples with sum 1023×8 (all 1023): `q_measured`=1023, no overflow. Samples 0,0,0,0,0,0,0,7: `q_measured`=0 (truncation).
- `iref_changed` on the 5th sample cycle of a window:
  - That sample is dropped and no `ready` is produced.
  - `settling` asserts for 4 cycles.
  - The next `ready` uses only 8 fresh post-settle samples.
- `enable`=0 mid-window then `enable`=1:
  - No `ready` is produced while disabled.
  - `q_measured` keeps its prior value.
  - Settling restarts.
- `rst`=1 for one cycle mid-window: next cycle all outputs are 0 and the state is IDLE. `rst` high with `enable` high: `ready` never asserts while in reset.
- With `Q_MEASURE_PEAK_EN` defined, samples 3,9,2,9,1,0,5,4: `q_measured`=9 with the same `ready` timing.
